riscv_muldiv_unit: RTL and testbench
====================================

# riscv_muldiv_unit

Parametrised iterative multiply/divide unit implementing the RV32M/RV64M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) for the RISC-V core. It sits beside the integer ALU in the execute stage. Operands and funct3 come from decode, and the result goes to the writeback mux. It uses one shift-add or shift-subtract step per cycle, with valid/ready handshakes on both sides so the core can stall on it. Divide-by-zero and signed overflow are resolved on a single-cycle fast path.

## Interface
- XLEN, 32, operand/result width; legal values 32 or 64.
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  request present.
- in_ready  output  1  unit can accept a request (high only in IDLE).
- funct3  input  3  operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1  input  XLEN  operand A (multiplicand / dividend).
- rs2  input  XLEN  operand B (multiplier / divisor).
- flush  input  1  synchronous abort of any in-flight or completed-but-unconsumed operation.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes result.
- result  output  XLEN  operation result, stable while out_valid is high.
- busy  output  1  high in CALC, FIX or DONE.

## Operation
- States:
  - IDLE: in_ready=1.
  - CALC: iterative loop.
  - FIX: sign correction and result select.
  - DONE: out_valid=1.
- IDLE to CALC: on in_valid&&in_ready.
  - Latch funct3.
  - Latch magnitudes of rs1/rs2. Negate an operand only if the op treats it as signed and its MSB is 1. MULHSU treats rs1 as signed and rs2 as unsigned.
  - Latch the result-sign flags.
  - Load the step counter with XLEN-1.
- IDLE to DONE (fast path, no CALC):
  - Divide by zero (rs2==0): DIV/DIVU give all-ones; REM/REMU give rs1.
  - Signed overflow (DIV/REM, rs1==1<<(XLEN-1), rs2==all-ones): DIV gives rs1; REM gives 0.
- CALC multiply: 2*XLEN-bit unsigned shift-add, one multiplier bit per cycle, LSB first.
- CALC divide: restoring division, one quotient bit per cycle, MSB first. The remainder register is XLEN+1 bits wide.
- CALC to FIX: when the counter reaches 0 (exactly XLEN CALC cycles).
- FIX, multiply: negate the 2*XLEN-bit product if the sign flag is set.
  - MUL selects the low XLEN bits.
  - MULH, MULHSU and MULHU select the high XLEN bits.
- FIX, divide:
  - Quotient sign = sign(rs1) XOR sign(rs2), signed ops only.
  - Remainder takes the sign of rs1.
- FIX to DONE: always.
- DONE to IDLE: on out_ready. The result is held unchanged until then.
- flush: from any state, go to IDLE on the next edge.
  - out_valid drops and no result is delivered.
  - flush has priority over in_valid and out_ready in the same cycle. A request presented while flush=1 is not accepted.
- rst: asynchronous, from any state including mid-CALC.
  - State becomes IDLE.
  - result, out_valid and busy become 0.
  - in_ready becomes 1 once rst deasserts.
  - All internal registers are cleared.
- Arithmetic is modulo 2^XLEN on the result. No exceptions or flags are raised.

## Timing
- Reset values: in_ready=1, out_valid=0, busy=0, result=0.
- Normal latency: request accepted at edge N; out_valid is high after edge N+XLEN+2 (34 cycles for XLEN=32).
- Fast-path latency: out_valid is high after edge N+1.
- in_ready is combinational from state only; it never depends on in_valid.
- out_valid is registered.
- Result consumed at edge M: in_ready is high after edge M. There is no same-cycle accept of a new request (one bubble).
- Throughput is one op per XLEN+3 cycles, assuming out_ready is held high.
- Inputs are sampled only at the accept edge. rs1, rs2 and funct3 may change freely afterwards.

## Test plan
- MUL 7 × 0xFFFFFFFD (-3), out_ready=1:
  - result=0xFFFFFFEB.
  - out_valid rises exactly 34 cycles after accept.
  - in_ready returns 1 cycle later.
- Multiply-high variants:
  - MULH 0x80000000×0x80000000 gives 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF gives 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×0x00000002 gives 0xFFFFFFFF.
- Signed/unsigned division of 0xFFFFFFF9 (-7) by 2:
  - DIV gives 0xFFFFFFFD.
  - REM gives 0xFFFFFFFF.
  - DIVU gives 0x7FFFFFFC.
  - REMU gives 1.
- Special cases, checking out_valid one cycle after accept:
  - DIV 5/0 gives 0xFFFFFFFF; REMU 5/0 gives 5.
  - DIV 0x80000000/0xFFFFFFFF gives 0x80000000; REM of the same gives 0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid.
  - result is stable, in_ready stays 0 and busy stays 1.
  - Pulse out_ready: out_valid falls and in_ready rises on the next edge.
- Abort:
  - Assert flush at CALC cycle 15: IDLE on the next edge, with no out_valid.
  - A new DIVU 100/7 then yields 14.
  - Assert rst at CALC cycle 20: outputs go to reset values immediately, before the next clock edge.

Source files
------------

// File: rtl/riscv_muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: one shift-add or restoring-divide step per cycle,
// with valid/ready handshakes on both sides and a single-cycle path for divide-by-zero and overflow.
module riscv_muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t              r_state;
    logic [2:0]          r_funct3;
    logic [XLEN-1:0]     r_opA;
    logic [XLEN-1:0]     r_opB;
    logic [2*XLEN-1:0]   r_acc;
    logic [XLEN:0]       r_rem;
    logic                r_negQ;
    logic                r_negR;
    logic [CW-1:0]       r_count;
    logic                r_outValid;
    logic [XLEN-1:0]     r_result;

    logic                w_aSigned;
    logic                w_bSigned;
    logic                w_aNeg;
    logic                w_bNeg;
    logic [XLEN-1:0]     w_absA;
    logic [XLEN-1:0]     w_absB;
    logic                w_divZero;
    logic                w_overflow;
    logic                w_fastPath;
    logic [XLEN-1:0]     w_fastResult;
    logic [XLEN:0]       w_mulSum;
    logic [XLEN:0]       w_divShift;
    logic [XLEN:0]       w_divTrial;
    logic                w_divFits;
    logic [2*XLEN-1:0]   w_product;
    logic [XLEN-1:0]     w_quotient;
    logic [XLEN-1:0]     w_remainder;
    logic [XLEN-1:0]     w_fixResult;

    assign in_ready  = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign out_valid = r_outValid;
    assign result    = r_result;

    // MULHSU treats only rs1 as signed; MUL needs no sign handling since its low half is sign-agnostic.
    assign w_aSigned = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                       (funct3 == 3'b100) || (funct3 == 3'b110);
    assign w_bSigned = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    assign w_aNeg    = w_aSigned && rs1[XLEN-1];
    assign w_bNeg    = w_bSigned && rs2[XLEN-1];
    assign w_absA    = w_aNeg ? -rs1 : rs1;
    assign w_absB    = w_bNeg ? -rs2 : rs2;

    assign w_divZero  = (rs2 == '0);
    assign w_overflow = !funct3[0] && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);
    assign w_fastPath = funct3[2] && (w_divZero || w_overflow);

    always_comb begin
        w_fastResult = '0;
        if (w_divZero) begin
            w_fastResult = funct3[1] ? rs1 : '1;
        end else begin
            w_fastResult = funct3[1] ? '0 : rs1;
        end
    end

    // Multiply keeps the multiplier in the low half of r_acc and shifts partial sums in from the top.
    assign w_mulSum   = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opA} : '0);
    assign w_divShift = {r_rem[XLEN-1:0], r_acc[XLEN-1]};
    assign w_divTrial = w_divShift - {1'b0, r_opB};
    assign w_divFits  = !w_divTrial[XLEN];

    assign w_product   = r_negQ ? -r_acc : r_acc;
    assign w_quotient  = r_negQ ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
    assign w_remainder = r_negR ? -r_rem[XLEN-1:0] : r_rem[XLEN-1:0];

    always_comb begin
        w_fixResult = '0;
        if (r_funct3[2]) begin
            w_fixResult = r_funct3[1] ? w_remainder : w_quotient;
        end else if (r_funct3[1:0] == 2'b00) begin
            w_fixResult = w_product[XLEN-1:0];
        end else begin
            w_fixResult = w_product[2*XLEN-1:XLEN];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_funct3   <= '0;
            r_opA      <= '0;
            r_opB      <= '0;
            r_acc      <= '0;
            r_rem      <= '0;
            r_negQ     <= 1'b0;
            r_negR     <= 1'b0;
            r_count    <= '0;
            r_outValid <= 1'b0;
            r_result   <= '0;
        end else if (flush) begin
            r_state    <= S_IDLE;
            r_outValid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_funct3 <= funct3;
                        if (w_fastPath) begin
                            r_result   <= w_fastResult;
                            r_outValid <= 1'b1;
                            r_state    <= S_DONE;
                        end else begin
                            r_opA   <= w_absA;
                            r_opB   <= w_absB;
                            r_acc   <= funct3[2] ? {{XLEN{1'b0}}, w_absA} : {{XLEN{1'b0}}, w_absB};
                            r_rem   <= '0;
                            r_negQ  <= w_aNeg ^ w_bNeg;
                            r_negR  <= w_aNeg;
                            r_count <= CW'(XLEN - 1);
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (r_funct3[2]) begin
                        r_acc[XLEN-1:0] <= {r_acc[XLEN-2:0], w_divFits};
                        r_rem           <= w_divFits ? w_divTrial : w_divShift;
                    end else begin
                        r_acc <= {w_mulSum, r_acc[XLEN-1:1]};
                    end
                    if (r_count == '0) begin
                        r_state <= S_FIX;
                    end else begin
                        r_count <= r_count - CW'(1);
                    end
                end
                S_FIX: begin
                    r_result   <= w_fixResult;
                    r_outValid <= 1'b1;
                    r_state    <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_outValid <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_muldiv_unit.sv
// Scoreboard bench for riscv_muldiv_unit: a driver queues reference results, a monitor checks
// every delivered result; directed cases cover latency, fast paths, backpressure, flush and reset.
module tb_riscv_muldiv_unit;

    localparam int XLEN = 32;
    localparam int NORMAL_LAT = 34;
    localparam int FAST_LAT = 1;
    localparam int TIMEOUT = 200;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [2:0]      funct3 = '0;
    logic [XLEN-1:0] rs1 = '0;
    logic [XLEN-1:0] rs2 = '0;
    logic            flush = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [XLEN-1:0] result;
    logic            busy;

    int              assertCount = 0;
    int              failCount = 0;
    logic [XLEN-1:0] expQ[$];

    riscv_muldiv_unit #(.XLEN(XLEN)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .funct3   (funct3),
        .rs1      (rs1),
        .rs2      (rs2),
        .flush    (flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Reference results straight from RISC-V M-extension arithmetic on 64-bit integers.
    function automatic logic [31:0] refModel(logic [2:0] f, logic [31:0] a, logic [31:0] b);
        longint          sa = $signed(a);
        longint          sb = $signed(b);
        longint unsigned ua = a;
        longint unsigned ub = b;
        logic [63:0]     p;
        case (f)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    function automatic bit isFast(logic [2:0] f, logic [31:0] a, logic [31:0] b);
        return f[2] && (b == 0 || ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    task automatic checkOutput(string name, logic [63:0] actual, logic [63:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic waitReady();
        int n = 0;
        while (!in_ready && n < TIMEOUT) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("in_ready_wait", in_ready, 1);
    endtask

    task automatic applyStimulus(logic [2:0] f, logic [31:0] a, logic [31:0] b, bit expectResult);
        waitReady();
        funct3   = f;
        rs1      = a;
        rs2      = b;
        in_valid = 1'b1;
        if (expectResult) expQ.push_back(refModel(f, a, b));
        @(posedge clk); #1;
        in_valid = 1'b0;
        funct3   = 3'($urandom);
        rs1      = $urandom;
        rs2      = $urandom;
    endtask

    task automatic waitResult(output int lat);
        lat = 1;
        while (!out_valid && lat < TIMEOUT) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic runOp(logic [2:0] f, logic [31:0] a, logic [31:0] b);
        int lat;
        applyStimulus(f, a, b, 1'b1);
        waitResult(lat);
        checkOutput("latency", lat, isFast(f, a, b) ? FAST_LAT : NORMAL_LAT);
        @(posedge clk); #1;
        checkOutput("out_valid_after_consume", out_valid, 0);
        checkOutput("in_ready_after_consume", in_ready, 1);
    endtask

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin : monitor
        logic [XLEN-1:0] expected;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_result", result, 64'hDEAD);
                end else begin
                    expected = expQ.pop_front();
                    checkOutput("result", result, expected);
                end
            end
        end
    end

    initial begin : driver
        int  lat;
        bit  sawValid;
        logic [31:0] bpExpected;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_result", result, 0);
        rst = 1'b0;
        #1;
        checkOutput("reset_in_ready", in_ready, 1);

        runOp(3'd0, 32'd7, 32'hFFFF_FFFD);
        runOp(3'd1, 32'h8000_0000, 32'h8000_0000);
        runOp(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        runOp(3'd2, 32'hFFFF_FFFF, 32'h0000_0002);
        runOp(3'd4, 32'hFFFF_FFF9, 32'd2);
        runOp(3'd6, 32'hFFFF_FFF9, 32'd2);
        runOp(3'd5, 32'hFFFF_FFF9, 32'd2);
        runOp(3'd7, 32'hFFFF_FFF9, 32'd2);
        runOp(3'd4, 32'd5, 32'd0);
        runOp(3'd7, 32'd5, 32'd0);
        runOp(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        runOp(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);

        for (int i = 0; i < 40; i++) begin
            runOp(3'($urandom), pickOperand(), pickOperand());
        end

        out_ready = 1'b0;
        bpExpected = refModel(3'd3, 32'hDEAD_BEEF, 32'h1234_5678);
        applyStimulus(3'd3, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1);
        waitResult(lat);
        checkOutput("bp_latency", lat, NORMAL_LAT);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checkOutput("bp_result_stable", result, bpExpected);
            checkOutput("bp_out_valid", out_valid, 1);
            checkOutput("bp_in_ready", in_ready, 0);
            checkOutput("bp_busy", busy, 1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("bp_out_valid_fall", out_valid, 0);
        checkOutput("bp_in_ready_rise", in_ready, 1);

        applyStimulus(3'd4, $urandom, 32'd3, 1'b1);
        repeat (14) begin @(posedge clk); #1; end
        flush = 1'b1;
        expQ.delete();
        @(posedge clk); #1;
        flush = 1'b0;
        checkOutput("flush_in_ready", in_ready, 1);
        checkOutput("flush_busy", busy, 0);
        checkOutput("flush_out_valid", out_valid, 0);
        sawValid = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) sawValid = 1'b1;
        end
        checkOutput("flush_no_result", sawValid, 0);

        flush    = 1'b1;
        in_valid = 1'b1;
        funct3   = 3'd5;
        rs1      = 32'd9;
        rs2      = 32'd2;
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        checkOutput("flush_blocks_accept_busy", busy, 0);
        checkOutput("flush_blocks_accept_ready", in_ready, 1);

        runOp(3'd5, 32'd100, 32'd7);
        checkOutput("divu_100_7_held", result, 32'd14);

        applyStimulus(3'd0, $urandom, $urandom, 1'b0);
        repeat (19) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        checkOutput("async_rst_out_valid", out_valid, 0);
        checkOutput("async_rst_busy", busy, 0);
        checkOutput("async_rst_result", result, 0);
        expQ.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checkOutput("post_rst_in_ready", in_ready, 1);

        runOp(3'd0, 32'd7, 32'hFFFF_FFFD);
        runOp(3'd6, 32'd17, 32'hFFFF_FFFB);

        repeat (5) @(posedge clk);
        checkOutput("scoreboard_drained", expQ.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
